// File: rtl/beam_angle_tracker.sv
// beam_angle_tracker: measures rotor revolution period from beam index edges
// and divides each revolution into NUM_COLS angular columns using a
// remainder-carrying phase accumulator (no divider).
module beam_angle_tracker #(
    parameter int NUM_COLS   = 128,
    parameter int CNT_WIDTH  = 32,
    parameter int MIN_PERIOD = 1000,
    parameter int MAX_PERIOD = 200000000,
    parameter int EDGE_POL   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beam_clean,
    output logic [$clog2(NUM_COLS)-1:0] col_idx,
    output logic                        col_tick,
    output logic                        rev_tick,
    output logic [CNT_WIDTH-1:0]        period,
    output logic                        locked
);

    localparam int COL_W = $clog2(NUM_COLS);

    // Constants sized to the arithmetic they take part in
    localparam logic [CNT_WIDTH:0]   MIN_P    = (CNT_WIDTH+1)'(MIN_PERIOD);
    localparam logic [CNT_WIDTH:0]   NCOLS    = (CNT_WIDTH+1)'(NUM_COLS);
    localparam logic [CNT_WIDTH-1:0] TO_CNT   = CNT_WIDTH'(MAX_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [COL_W-1:0]     LAST_COL = COL_W'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 beam_prev_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [COL_W-1:0]     col_idx_q, col_idx_d;
    logic                 col_tick_q, col_tick_d;
    logic                 rev_tick_q, rev_tick_d;
    logic                 locked_q, locked_d;

    logic                 idx_evt;
    logic                 accept;
    logic                 timeout;
    logic [CNT_WIDTH:0]   p;
    logic [CNT_WIDTH:0]   acc_n;

    // Edge detect, measured period and accept/timeout qualifiers
    always_comb begin
        if (EDGE_POL != 0) idx_evt = beam_clean & ~beam_prev_q;
        else               idx_evt = ~beam_clean & beam_prev_q;
        // p is one bit wider so a saturated counter cannot wrap to 0
        p       = {1'b0, cnt_q} + 1'b1;
        accept  = idx_evt && ((state_q == IDLE) || (p >= MIN_P));
        timeout = (state_q != IDLE) && (cnt_q == TO_CNT);
        acc_n   = {1'b0, acc_q} + NCOLS;
    end

    // Next-state, counter, accumulator and output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        acc_d      = acc_q;
        period_d   = period_q;
        col_idx_d  = col_idx_q;
        col_tick_d = 1'b0;
        rev_tick_d = 1'b0;

        if (accept) cnt_d = '0;

        case (state_q)
            IDLE: begin
                col_idx_d = '0;
                if (accept) state_d = MEASURE;
            end
            MEASURE, LOCKED: begin
                if (accept) begin
                    // Index wins over any column advance in the same cycle
                    state_d    = LOCKED;
                    period_d   = CNT_WIDTH'(p);
                    acc_d      = '0;
                    col_idx_d  = '0;
                    rev_tick_d = 1'b1;
                    col_tick_d = 1'b1;
                end else if (timeout) begin
                    state_d   = IDLE;
                    period_d  = '0;
                    acc_d     = '0;
                    col_idx_d = '0;
                end else if (state_q == LOCKED) begin
                    // Remainder stays in acc so column error never accumulates
                    if (acc_n >= {1'b0, period_q}) begin
                        acc_d = CNT_WIDTH'(acc_n - {1'b0, period_q});
                        if (col_idx_q < LAST_COL) begin
                            col_idx_d  = col_idx_q + 1'b1;
                            col_tick_d = 1'b1;
                        end
                    end else begin
                        acc_d = CNT_WIDTH'(acc_n);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                col_idx_d = '0;
                period_d  = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beam_prev_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            period_q    <= '0;
            col_idx_q   <= '0;
            col_tick_q  <= 1'b0;
            rev_tick_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beam_prev_q <= beam_clean;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            period_q    <= period_d;
            col_idx_q   <= col_idx_d;
            col_tick_q  <= col_tick_d;
            rev_tick_q  <= rev_tick_d;
            locked_q    <= locked_d;
        end
    end

    assign col_idx  = col_idx_q;
    assign col_tick = col_tick_q;
    assign rev_tick = rev_tick_q;
    assign period   = period_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_beam_angle_tracker.sv
// tb_beam_angle_tracker: directed scenarios for beam_angle_tracker with
// NUM_COLS=8, MIN_PERIOD=16, MAX_PERIOD=4096, rising-edge index.
module tb_beam_angle_tracker;

    localparam int NC = 8;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        beam = 1'b0;
    logic [2:0]  col_idx;
    logic        col_tick;
    logic        rev_tick;
    logic [31:0] period;
    logic        locked;

    int checks   = 0;
    int failures = 0;

    beam_angle_tracker #(
        .NUM_COLS  (NC),
        .CNT_WIDTH (32),
        .MIN_PERIOD(16),
        .MAX_PERIOD(4096),
        .EDGE_POL  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .beam_clean(beam),
        .col_idx   (col_idx),
        .col_tick  (col_tick),
        .rev_tick  (rev_tick),
        .period    (period),
        .locked    (locked)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle high beam pulse: rising edge is sampled by this step
    task automatic idx_edge();
        beam = 1'b1;
        step();
        beam = 1'b0;
    endtask

    // Runs gap-1 cycles after an index with a locked period per, optionally
    // inserting a short beam pulse at cycle glitch. Expected column is the
    // ideal floor(k*NC/per) clamped to the last column; tick when it changes.
    task automatic run_rev(input int gap, input int per, input int glitch,
                           output int bad, output int first_k);
        int ec, ep;
        logic [5:0] exp_v, act_v;
        bad = 0;
        first_k = -1;
        for (int k = 1; k < gap; k++) begin
            beam = (k == glitch);
            step();
            ec = (NC * k) / per;
            ep = (NC * (k - 1)) / per;
            exp_v = {3'((ec > NC - 1) ? NC - 1 : ec),
                     1'((ec != ep) && (ec <= NC - 1)), 1'b0, 1'b1};
            act_v = {col_idx, col_tick, rev_tick, locked};
            if (act_v !== exp_v) begin
                bad++;
                if (first_k < 0) first_k = k;
            end
        end
        beam = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            beam = (i % 2 == 0);
            step();
        end
        beam = 1'b0;
        checks++; if (col_idx !== 3'd0) begin failures++; $display("FAIL reset_col got=%0d exp=0", col_idx); end
        checks++; if (col_tick !== 1'b0) begin failures++; $display("FAIL reset_col_tick got=%b exp=0", col_tick); end
        checks++; if (rev_tick !== 1'b0) begin failures++; $display("FAIL reset_rev_tick got=%b exp=0", rev_tick); end
        checks++; if (period !== 32'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked); end
        rst = 1'b0;
        step();
        idx_edge();
        checks++; if (rev_tick !== 1'b0) begin failures++; $display("FAIL first_edge_rev got=%b exp=0", rev_tick); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL first_edge_locked got=%b exp=0", locked); end
    endtask

    task automatic test_lock_cols();
        int bad, fk;
        steps(799);
        idx_edge();
        checks++; if ({rev_tick, col_tick, locked} !== 3'b111) begin failures++; $display("FAIL lock_ticks got=%b exp=111", {rev_tick, col_tick, locked}); end
        checks++; if (col_idx !== 3'd0) begin failures++; $display("FAIL lock_col got=%0d exp=0", col_idx); end
        checks++; if (period !== 32'd800) begin failures++; $display("FAIL lock_period got=%0d exp=800", period); end
        run_rev(800, 800, 0, bad, fk);
        checks++; if (bad !== 0) begin failures++; $display("FAIL lock_columns bad_cycles=%0d first_at=%0d exp=0", bad, fk); end
        idx_edge();
        checks++; if ({rev_tick, col_tick, col_idx} !== 5'b11000) begin failures++; $display("FAIL second_index got=%b exp=11000", {rev_tick, col_tick, col_idx}); end
        checks++; if (period !== 32'd800) begin failures++; $display("FAIL second_period got=%0d exp=800", period); end
    endtask

    task automatic test_glitch();
        int bad, fk;
        run_rev(800, 800, 5, bad, fk);
        checks++; if (bad !== 0) begin failures++; $display("FAIL glitch_columns bad_cycles=%0d first_at=%0d exp=0", bad, fk); end
        idx_edge();
        checks++; if (period !== 32'd800) begin failures++; $display("FAIL glitch_period got=%0d exp=800", period); end
        checks++; if (rev_tick !== 1'b1) begin failures++; $display("FAIL glitch_rev got=%b exp=1", rev_tick); end
    endtask

    task automatic test_slowdown();
        int bad, fk;
        run_rev(1000, 800, 0, bad, fk);
        checks++; if (bad !== 0) begin failures++; $display("FAIL slow_hold bad_cycles=%0d first_at=%0d exp=0", bad, fk); end
        idx_edge();
        checks++; if (period !== 32'd1000) begin failures++; $display("FAIL slow_period got=%0d exp=1000", period); end
        run_rev(1000, 1000, 0, bad, fk);
        checks++; if (bad !== 0) begin failures++; $display("FAIL slow_columns bad_cycles=%0d first_at=%0d exp=0", bad, fk); end
        idx_edge();
        checks++; if ({rev_tick, col_idx} !== 4'b1000) begin failures++; $display("FAIL slow_next_index got=%b exp=1000", {rev_tick, col_idx}); end
    endtask

    task automatic test_timeout();
        steps(4095);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL pre_timeout_locked got=%b exp=1", locked); end
        checks++; if (col_idx !== 3'd7) begin failures++; $display("FAIL pre_timeout_col got=%0d exp=7", col_idx); end
        step();
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL timeout_locked got=%b exp=0", locked); end
        checks++; if (col_idx !== 3'd0) begin failures++; $display("FAIL timeout_col got=%0d exp=0", col_idx); end
        checks++; if (period !== 32'd0) begin failures++; $display("FAIL timeout_period got=%0d exp=0", period); end
        checks++; if ({col_tick, rev_tick} !== 2'b00) begin failures++; $display("FAIL timeout_ticks got=%b exp=00", {col_tick, rev_tick}); end
        idx_edge();
        checks++; if ({rev_tick, locked} !== 2'b00) begin failures++; $display("FAIL timeout_measure got=%b exp=00", {rev_tick, locked}); end
        steps(799);
        idx_edge();
        checks++; if ({rev_tick, locked} !== 2'b11) begin failures++; $display("FAIL timeout_relock got=%b exp=11", {rev_tick, locked}); end
        checks++; if (period !== 32'd800) begin failures++; $display("FAIL timeout_relock_period got=%0d exp=800", period); end
    endtask

    task automatic test_mid_reset();
        steps(500);
        checks++; if (col_idx !== 3'd5) begin failures++; $display("FAIL mid_col got=%0d exp=5", col_idx); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({col_idx, col_tick, rev_tick, locked} !== 6'd0) begin failures++; $display("FAIL mid_reset_flags got=%b exp=000000", {col_idx, col_tick, rev_tick, locked}); end
        checks++; if (period !== 32'd0) begin failures++; $display("FAIL mid_reset_period got=%0d exp=0", period); end
        idx_edge();
        checks++; if ({rev_tick, locked} !== 2'b00) begin failures++; $display("FAIL mid_first_edge got=%b exp=00", {rev_tick, locked}); end
        steps(799);
        idx_edge();
        checks++; if ({rev_tick, locked} !== 2'b11) begin failures++; $display("FAIL mid_relock got=%b exp=11", {rev_tick, locked}); end
        checks++; if (period !== 32'd800) begin failures++; $display("FAIL mid_relock_period got=%0d exp=800", period); end
    endtask

    initial begin
        test_reset();
        test_lock_cols();
        test_glitch();
        test_slowdown();
        test_timeout();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beam_angle_tracker.md
Name: beam_angle_tracker

Overview:
- Sits directly downstream of the breakbeam debouncer and consumes its clean, clk-synchronous beam level.
- Each qualifying beam edge is one rotor revolution index. The block measures the revolution period in clk cycles.
- It splits the next revolution into NUM_COLS equal angular columns using a phase accumulator (no divider).
- The current column index drives the LED column/frame-buffer read logic.

Parameters:
- NUM_COLS, 128: columns per revolution; any value >= 2, not required to be a power of 2.
- CNT_WIDTH, 32: width of the period counter, period output and accumulator.
- MIN_PERIOD, 1000: index events with measured period < MIN_PERIOD are rejected as glitches.
- MAX_PERIOD, 200000000: no index for MAX_PERIOD cycles means the rotor is stopped (timeout).
- EDGE_POL, 1: 1 = index on 0->1 of beam_clean; 0 = index on 1->0.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- beam_clean  in  1  debounced, already-synchronized beam level.
- col_idx  out  $clog2(NUM_COLS)  current angular column.
- col_tick  out  1  one-cycle pulse when a new column starts (including column 0 at index).
- rev_tick  out  1  one-cycle pulse on each accepted index.
- period  out  CNT_WIDTH  last accepted revolution period, in cycles.
- locked  out  1  high while columns are being generated from a valid period.

Behaviour:
- Reset: all outputs are 0 on the cycle after rst is sampled high. Internal counters, the accumulator and beam_prev are cleared. State goes to IDLE.
- rst overrides everything, including mid-LOCKED.
- Edge detect: beam_prev is a register of beam_clean. idx_evt is combinational: (beam_clean & ~beam_prev) when EDGE_POL=1, else the inverse.
- Latency: all outputs are registered and respond 1 cycle after the cycle idx_evt is true.
- Period counter (cnt):
  - On an accepted index, cnt <= 0. Otherwise cnt <= cnt+1, saturating at all-ones.
  - Measured period p = cnt+1, sampled in the idx_evt cycle.
  - Example: index cycles at T and T+800 give p = 800.
- Accept rule: an idx_evt is accepted if the state is IDLE, or if p >= MIN_PERIOD. Otherwise it is ignored and cnt keeps counting.
- States:
  - IDLE: locked=0, col_idx=0. Accepted idx_evt -> MEASURE with cnt<=0. No rev_tick.
  - MEASURE: counting the first period. Accepted idx_evt -> LOCKED, with:
    - period<=p, acc<=0, col_idx<=0;
    - rev_tick=1, col_tick=1, locked=1.
  - LOCKED: each non-index cycle:
    - acc_n = acc + NUM_COLS, computed in CNT_WIDTH+1 bits.
    - If acc_n >= period: acc <= acc_n - period. If col_idx < NUM_COLS-1, then col_idx++ and col_tick=1.
    - Otherwise acc <= acc_n.
  - LOCKED, accepted idx_evt: period<=p, acc<=0, col_idx<=0, rev_tick=1, col_tick=1. Any column advance in that same cycle is discarded (index wins).
- Timeout: in MEASURE or LOCKED, when cnt reaches MAX_PERIOD-1 without an accepted index:
  - go to IDLE;
  - locked<=0, col_idx<=0, period<=0;
  - no ticks.
- Saturation: if the rotor slows, col_idx holds at NUM_COLS-1 with no further col_tick until the next index.
- Speed-up: if the index arrives before column NUM_COLS-1, col_idx jumps to 0; the remaining columns are skipped.
- Exactly NUM_COLS column starts per revolution at constant speed. Cumulative error is zero because the accumulator carries the remainder.
- col_tick and rev_tick are never high for more than one consecutive cycle from the same event.

Test Plan:
- Reset: hold rst for 3 cycles with beam toggling -> col_idx=0, col_tick=0, rev_tick=0, period=0, locked=0. First edge after release puts the block in MEASURE only (no rev_tick).
- Lock and columns (NUM_COLS=8, MIN_PERIOD=16, EDGE_POL=1): rising edges at cycles 0, 800, 1600 ->
  - after 800: period=800, locked=1, rev_tick one pulse, col_idx=0;
  - col_tick every 100 cycles, with col_idx 1..7 at 900..1500;
  - edge at 1600 -> col_idx=0, rev_tick.
- Glitch rejection: while locked at 800, an extra edge 5 cycles after an index -> ignored. No rev_tick, col_idx sequence and next period=800 unchanged.
- Slowdown: locked at 800, next index arrives 1000 cycles later -> col_idx reaches 7 at +700 and holds with no col_tick until the index. Then period=1000 and columns every 125 cycles.
- Timeout (MAX_PERIOD=4096): locked, then no edges -> at 4096 cycles after the last index, locked=0, col_idx=0, period=0. Next edge -> MEASURE; following edge -> LOCKED.
- Mid-operation reset: assert rst at col_idx=5 -> next cycle all outputs 0, state IDLE. Relock requires two accepted edges.
